serial_input_conditioner: RTL

SERIAL_INPUT_CONDITIONER -- requirements
Module: serial_input_conditioner

---
 rtl/serial_input_conditioner.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_input_conditioner.sv
// Push-button conditioner: synchronizes key_n/data_raw, debounces the key and
// emits one step pulse per accepted press with the data bit captured at that press.
module serial_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    input  logic       data_raw,
    output logic       step,
    output logic       w_out,
    output logic [7:0] step_count,
    output logic       busy
);
    // state        | meaning
    // IDLE         | key released and stable
    // PRESS_WAIT   | key low, counting toward an accepted press
    // PRESSED      | press accepted, waiting for the key to rise
    // RELEASE_WAIT | key high, counting toward an accepted release
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    logic [19:0] cnt;
    logic        key_meta;
    logic        key_sync;
    logic        data_meta;
    logic        data_sync;

    // key idles released (high), so its synchronizer resets to 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            key_meta  <= key_n;
            key_sync  <= key_meta;
            data_meta <= data_raw;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            step       <= 1'b0;
            w_out      <= 1'b0;
            step_count <= '0;
            busy       <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (key_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= PRESSED;
                        step       <= 1'b1;
                        w_out      <= data_sync;
                        step_count <= step_count + 8'd1;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                PRESSED: begin
                    if (key_sync) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // a low during release is bounce, not a new press
                    if (!key_sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
